// File: rtl/t03_memory_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// t03_mem_pkg
// Shared types and defaults for the memory arbiter slice.
//   arb_state_t : arbiter FSM states
//   grant_t     : which requester won the most recent grant
//   DEFAULT_*   : default timeout limit and timeout counter width
// ---------------------------------------------------------------------------
package t03_mem_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_BUS  = 3'd1,
    I_FILL = 3'd2,
    D_BUS  = 3'd3,
    D_DONE = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/t03_memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// t03_memory_arbiter_if
// External single-word memory bus.
//   bus_req   : bus cycle request (held until ack or abort)
//   bus_we    : write enable
//   bus_addr  : word/byte address
//   bus_wdata : write data
//   bus_sel   : byte enables
//   bus_rdata : read data, valid together with bus_ack
//   bus_ack   : one-cycle transfer acknowledge
// master = arbiter side, slave = memory side.
// ---------------------------------------------------------------------------
interface t03_memory_arbiter_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/t03_memory_arbiter_bus_timeout.sv
// ---------------------------------------------------------------------------
// t03_bus_timeout
// Wait-cycle counter guarding one bus access.
//   clk, nrst : clock, asynchronous active-low reset
//   clear     : hold the count at zero (asserted whenever no access is open)
//   enable    : an access is open and was not acknowledged this cycle
//   expired   : this is the TIMEOUT-th unacknowledged cycle of the access
// expired is gated by enable, so an ack in the final cycle wins.
// ---------------------------------------------------------------------------
module t03_bus_timeout
  import t03_mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Count value seen during the last permitted wait cycle.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = enable && (cnt == LIMIT);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/t03_memory_arbiter.sv
// ---------------------------------------------------------------------------
// t03_memory_arbiter
// Owns the external memory bus and shares it between the instruction-cache
// miss path and the core load/store path. One word per transaction.
//   clk, nrst          : clock, asynchronous active-low reset
//   i_req, i_addr      : fetch miss pending / fetch address
//   i_fill, i_done     : one-cycle fill strobe / fetch-complete pulse
//   i_instr            : fetched word, held until the next fetch completes
//   d_read, d_write    : load / store request (both high = store)
//   d_addr, d_wdata    : data address / store data
//   d_sel              : byte enables
//   d_rdata            : load data, held until the next load completes
//   d_done             : one-cycle data-complete pulse
//   err                : one-cycle pulse with i_done/d_done on a timed-out access
//   bus                : memory bus, master side
// All outputs decode registered state and latches only.
// ---------------------------------------------------------------------------
module t03_memory_arbiter
  import t03_mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        i_req,
  input  logic [31:0]                 i_addr,
  output logic                        i_fill,
  output logic [31:0]                 i_instr,
  output logic                        i_done,
  input  logic                        d_read,
  input  logic                        d_write,
  input  logic [31:0]                 d_addr,
  input  logic [31:0]                 d_wdata,
  input  logic [3:0]                  d_sel,
  output logic [31:0]                 d_rdata,
  output logic                        d_done,
  output logic                        err,
  t03_memory_arbiter_if.master        bus
);

  arb_state_t  state, state_n;
  grant_t      last_grant, last_grant_n;

  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_sel;
  logic        lat_we;

  logic        latch_i, latch_d;
  logic        capture_i, capture_d;
  logic [31:0] capture_word;
  logic        err_n;

  logic        d_any;
  logic        pick_i, pick_d;
  logic        in_bus;
  logic        tmo_expired;

  // On a tie the side that did not win last time is granted.
  assign d_any  = d_read | d_write;
  assign pick_d = d_any && (!i_req || (last_grant == GRANT_I));
  assign pick_i = i_req && !pick_d;

  assign in_bus = (state == I_BUS) || (state == D_BUS);

  t03_bus_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (!in_bus),
    .enable  (in_bus && !bus.bus_ack),
    .expired (tmo_expired)
  );

  // Next-state and capture decisions
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    latch_i      = 1'b0;
    latch_d      = 1'b0;
    capture_i    = 1'b0;
    capture_d    = 1'b0;
    capture_word = bus.bus_rdata;
    err_n        = 1'b0;

    case (state)
      IDLE: begin
        if (pick_d) begin
          state_n      = D_BUS;
          last_grant_n = GRANT_D;
          latch_d      = 1'b1;
        end else if (pick_i) begin
          state_n      = I_BUS;
          last_grant_n = GRANT_I;
          latch_i      = 1'b1;
        end
      end

      I_BUS: begin
        if (bus.bus_ack) begin
          capture_i = 1'b1;
          state_n   = I_FILL;
        end else if (tmo_expired) begin
          capture_i    = 1'b1;
          capture_word = 32'h0;
          err_n        = 1'b1;
          state_n      = I_FILL;
        end
      end

      I_FILL: state_n = IDLE;

      D_BUS: begin
        // Stores never disturb the held load data.
        if (bus.bus_ack) begin
          capture_d = !lat_we;
          state_n   = D_DONE;
        end else if (tmo_expired) begin
          capture_d    = !lat_we;
          capture_word = 32'h0;
          err_n        = 1'b1;
          state_n      = D_DONE;
        end
      end

      D_DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      err        <= 1'b0;
      i_instr    <= 32'h0;
      d_rdata    <= 32'h0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      err        <= err_n;
      if (capture_i) i_instr <= capture_word;
      if (capture_d) d_rdata <= capture_word;
    end
  end

  // Transaction latches, only observable while an access is open
  always_ff @(posedge clk) begin
    if (latch_d) begin
      lat_addr  <= d_addr;
      lat_wdata <= d_wdata;
      lat_sel   <= d_sel;
      lat_we    <= d_write;
    end else if (latch_i) begin
      lat_addr  <= i_addr;
      lat_sel   <= 4'hF;
      lat_we    <= 1'b0;
    end
  end

  // Output decode
  assign bus.bus_req   = in_bus;
  assign bus.bus_we    = (state == D_BUS) && lat_we;
  assign bus.bus_sel   = in_bus ? lat_sel : 4'h0;
  assign bus.bus_addr  = (state == I_BUS) ? {lat_addr[31:2], 2'b00} :
                         (state == D_BUS) ? lat_addr : 32'h0;
  assign bus.bus_wdata = (state == D_BUS) ? lat_wdata : 32'h0;

  assign i_fill = (state == I_FILL);
  assign i_done = (state == I_FILL);
  assign d_done = (state == D_DONE);

endmodule

// File: tb/tb_t03_memory_arbiter.sv
module tb_t03_memory_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_fill;
  logic [31:0] i_instr;
  logic        i_done;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_sel;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        err;

  t03_memory_arbiter_if bus_if ();

  t03_memory_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_fill  (i_fill),
    .i_instr (i_instr),
    .i_done  (i_done),
    .d_read  (d_read),
    .d_write (d_write),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_sel   (d_sel),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .err     (err),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: held results and who won the last grant.
  logic [31:0] m_instr;
  logic [31:0] m_rdata;
  bit          last_was_d;

  typedef struct {
    bit          is_i;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          w;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    bit          exp_we;
    logic [3:0]  exp_sel;
    bit          exp_err;
    logic [31:0] exp_instr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[8];

  function automatic vec_t mk(bit is_i, bit rd, bit wr, logic [31:0] addr,
                              logic [31:0] wdata, logic [3:0] sel, int w,
                              logic [31:0] rdata, logic [31:0] exp_addr,
                              bit exp_we, logic [3:0] exp_sel, bit exp_err,
                              logic [31:0] exp_instr, logic [31:0] exp_rdata);
    vec_t v;
    v.is_i = is_i; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.sel = sel; v.w = w; v.rdata = rdata; v.exp_addr = exp_addr;
    v.exp_we = exp_we; v.exp_sel = exp_sel; v.exp_err = exp_err;
    v.exp_instr = exp_instr; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_reqs();
    i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  // Called in a cycle where the request is already driven and the arbiter is
  // idle. Returns in the done/fill cycle after checking it.
  task automatic run_txn(input bit is_i, input logic [31:0] exp_addr, input bit exp_we,
                         input logic [3:0] exp_sel, input logic [31:0] exp_wdata,
                         input int w, input logic [31:0] rdata, input bit exp_err,
                         input logic [31:0] exp_instr, input logic [31:0] exp_rdata,
                         input bit drop_mid);
    logic [31:0] act_wd;
    logic [31:0] exp_wd;
    @(posedge clk); #1;
    for (int j = 1; j <= TMO; j++) begin
      act_wd = is_i ? 32'h0 : bus_if.bus_wdata;
      exp_wd = is_i ? 32'h0 : exp_wdata;
      chk("bus_cycle", {bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel, bus_if.bus_addr, act_wd},
                       {1'b1, exp_we, exp_sel, exp_addr, exp_wd});
      if (drop_mid && j == 1) clear_reqs();
      if (j == w + 1) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rdata;
      end
      @(posedge clk); #1;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = $urandom;
      if (j == w + 1) break;
    end
    chk("done_pulses", {i_fill, i_done, d_done, err},
        is_i ? {1'b1, 1'b1, 1'b0, exp_err} : {1'b0, 1'b0, 1'b1, exp_err});
    chk("bus_req_at_done", {31'h0, bus_if.bus_req}, 32'h0);
    chk("i_instr", i_instr, exp_instr);
    chk("d_rdata", d_rdata, exp_rdata);
    // Stray acknowledge while no access is open must be ignored.
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'hBAD0_BAD0;
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    bus_if.bus_ack = 1'b0;
    chk("after_done", {i_fill, i_done, d_done, err, bus_if.bus_req}, 5'h0);
  endtask

  // Behavioural model for one granted transaction.
  task automatic model_txn(input bit is_i, input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input logic [3:0] sel, input bit we,
                           input int w, input logic [31:0] rdata, input bit drop_mid);
    bit          to;
    logic [31:0] word;
    to   = (w + 1) > TMO;
    word = to ? 32'h0 : rdata;
    if (is_i) m_instr = word;
    else if (!we) m_rdata = word;
    last_was_d = !is_i;
    if (is_i)
      run_txn(1'b1, ia & 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, w, rdata, to, m_instr, m_rdata, drop_mid);
    else
      run_txn(1'b0, da, we, sel, wd, w, rdata, to, m_instr, m_rdata, drop_mid);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    bit want_i, want_d, we, side_d;
    int kind;
    logic [31:0] ia, da, wd;
    logic [3:0]  sl;

    nrst = 1'b0;
    clear_reqs();
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_sel = 4'h0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    m_instr = 32'h0; m_rdata = 32'h0; last_was_d = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {i_fill, i_done, d_done, err, bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel}, 10'h0);
    chk("reset_bus", {bus_if.bus_addr, bus_if.bus_wdata}, 64'h0);
    chk("reset_data", {i_instr, d_rdata}, 64'h0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // Tie after reset: data first, then the waiting instruction request.
    i_req = 1'b1; i_addr = 32'h0000_0040;
    d_read = 1'b1; d_addr = 32'h0000_0080; d_sel = 4'hF; d_wdata = 32'h1;
    model_txn(1'b0, i_addr, d_addr, d_wdata, d_sel, 1'b0, 0, 32'h1111_1111, 1'b0);
    d_read = 1'b0;
    idle_check();
    model_txn(1'b1, i_addr, d_addr, d_wdata, d_sel, 1'b0, 1, 32'h2222_2222, 1'b0);
    clear_reqs();
    idle_check();
    // Last winner was instruction; a data-only transaction flips it, so the
    // next tie goes to instruction.
    d_read = 1'b1; d_addr = 32'h0000_0090;
    model_txn(1'b0, i_addr, d_addr, d_wdata, d_sel, 1'b0, 0, 32'h3333_3333, 1'b0);
    clear_reqs();
    idle_check();
    i_req = 1'b1; i_addr = 32'h0000_0050; d_write = 1'b1; d_addr = 32'h0000_00A0;
    d_wdata = 32'h4444_4444; d_sel = 4'h3;
    model_txn(1'b1, i_addr, d_addr, d_wdata, d_sel, 1'b1, 0, 32'h5555_5555, 1'b0);
    i_req = 1'b0;
    idle_check();
    model_txn(1'b0, i_addr, d_addr, d_wdata, d_sel, 1'b1, 0, 32'h6666_6666, 1'b0);
    clear_reqs();
    idle_check();

    // Directed vectors. Held results before the table: i_instr=55555555,
    // d_rdata=33333333.
    tbl[0] = mk(1, 0, 0, 32'h0000_0046, 32'h0, 4'h0, 2, 32'h0051_0113,
                32'h0000_0044, 0, 4'hF, 0, 32'h0051_0113, 32'h3333_3333);
    tbl[1] = mk(0, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 0, 32'h1234_5678,
                32'h0000_0100, 1, 4'b0011, 0, 32'h0051_0113, 32'h3333_3333);
    tbl[2] = mk(0, 1, 0, 32'h0000_0204, 32'h0, 4'hF, 1, 32'hCAFE_F00D,
                32'h0000_0204, 0, 4'hF, 0, 32'h0051_0113, 32'hCAFE_F00D);
    tbl[3] = mk(0, 1, 0, 32'h0000_0208, 32'h0, 4'hF, 7, 32'h7777_7777,
                32'h0000_0208, 0, 4'hF, 1, 32'h0051_0113, 32'h0000_0000);
    tbl[4] = mk(1, 0, 0, 32'h0000_1003, 32'h0, 4'h0, 3, 32'hA5A5_0001,
                32'h0000_1000, 0, 4'hF, 0, 32'hA5A5_0001, 32'h0000_0000);
    tbl[5] = mk(1, 0, 0, 32'h0000_2000, 32'h0, 4'h0, 0, 32'h0000_0000,
                32'h0000_2000, 0, 4'hF, 0, 32'h0000_0000, 32'h0000_0000);
    tbl[6] = mk(0, 1, 0, 32'h0000_0300, 32'h0, 4'hF, 0, 32'h0BAD_CAFE,
                32'h0000_0300, 0, 4'hF, 0, 32'h0000_0000, 32'h0BAD_CAFE);
    tbl[7] = mk(0, 1, 1, 32'h0000_0304, 32'h0000_55AA, 4'b1100, 2, 32'h8888_8888,
                32'h0000_0304, 1, 4'b1100, 0, 32'h0000_0000, 32'h0BAD_CAFE);
    for (int k = 0; k < 8; k++) begin
      i_req = tbl[k].is_i; i_addr = tbl[k].addr;
      d_read = tbl[k].rd; d_write = tbl[k].wr; d_addr = tbl[k].addr;
      d_wdata = tbl[k].wdata; d_sel = tbl[k].sel;
      run_txn(tbl[k].is_i, tbl[k].exp_addr, tbl[k].exp_we, tbl[k].exp_sel, tbl[k].wdata,
              tbl[k].w, tbl[k].rdata, tbl[k].exp_err, tbl[k].exp_instr, tbl[k].exp_rdata, 1'b0);
      clear_reqs();
      idle_check();
    end
    m_instr = 32'h0; m_rdata = 32'h0BAD_CAFE; last_was_d = 1'b1;

    // Load dropped during the bus access still completes.
    d_read = 1'b1; d_addr = 32'h0000_0400; d_sel = 4'hF;
    model_txn(1'b0, i_addr, d_addr, d_wdata, d_sel, 1'b0, 2, 32'h0404_0404, 1'b1);
    clear_reqs();
    idle_check();

    // Asynchronous reset in the middle of a fetch.
    i_req = 1'b1; i_addr = 32'h0000_0500;
    @(posedge clk); #1;
    chk("bus_req_before_reset", {31'h0, bus_if.bus_req}, 32'h1);
    #2 nrst = 1'b0;
    #1;
    chk("reset_mid_fetch", {bus_if.bus_req, i_fill, i_done, d_done, err}, 5'h0);
    chk("reset_mid_data", {i_instr, d_rdata}, 64'h0);
    i_req = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    m_instr = 32'h0; m_rdata = 32'h0; last_was_d = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", {bus_if.bus_req, i_fill, i_done, d_done, err}, 5'h0);
    // Grant history is back to "instruction", so a tie goes to data.
    i_req = 1'b1; i_addr = 32'h0000_0600; d_write = 1'b1; d_addr = 32'h0000_0700;
    d_wdata = 32'h0707_0707; d_sel = 4'hC;
    model_txn(1'b0, i_addr, d_addr, d_wdata, d_sel, 1'b1, 1, 32'h0, 1'b0);
    d_write = 1'b0;
    idle_check();
    model_txn(1'b1, i_addr, d_addr, d_wdata, d_sel, 1'b0, 0, 32'h0606_0606, 1'b0);
    clear_reqs();
    idle_check();

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      kind   = $urandom_range(0, 5);
      want_i = (kind == 0) || (kind >= 4);
      d_read = (kind == 1) || (kind == 3) || (kind == 4);
      d_write = (kind == 2) || (kind == 3) || (kind == 5);
      want_d = d_read || d_write;
      we     = d_write;
      ia = $urandom; da = $urandom; wd = $urandom; sl = 4'($urandom_range(1, 15));
      i_req = want_i; i_addr = ia; d_addr = da; d_wdata = wd; d_sel = sl;
      while (want_i || want_d) begin
        side_d = (want_i && want_d) ? !last_was_d : want_d;
        model_txn(!side_d, ia, da, wd, sl, we, $urandom_range(0, 5),
                  ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, 1'b0);
        if (side_d) begin
          d_read = 1'b0; d_write = 1'b0; want_d = 1'b0;
        end else begin
          i_req = 1'b0; want_i = 1'b0;
        end
        idle_check();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/t03_memory_arbiter.md
# t03_memory_arbiter

Controller that owns the single external memory bus and shares it between the instruction cache miss path and the core's load/store path. On an instruction-cache miss it fetches the word, presents it on the cache fill inputs with a one-cycle fill strobe, and releases the fetch stall. Data requests are passed through as single-word bus transactions. A timeout guards every bus access. It sits between the core/instruction cache and the top-level memory bus.

## Interface
- TIMEOUT, 255: max cycles waiting for bus_ack before abort (≥1)
- CNT_W, 8: timeout counter width; TIMEOUT must fit in CNT_W bits
- clk  in  1  system clock
- nrst  in  1  asynchronous, active-low reset
- i_req  in  1  instruction fetch miss pending (core drives !hit)
- i_addr  in  32  fetch address (current PC)
- i_fill  out  1  one-cycle fill strobe to cache_read of the instruction cache
- i_instr  out  32  fetched word to cache input_instruction and core; held until next fetch completes
- i_done  out  1  one-cycle fetch-complete pulse, coincident with i_fill
- d_read / d_write  in  1  data load / store request
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_sel  in  4  byte enables
- d_rdata  out  32  load data; held until next data completion
- d_done  out  1  one-cycle data-complete pulse
- err  out  1  one-cycle pulse with i_done/d_done when the access timed out
- bus_req, bus_we  out  1  bus cycle request / write enable
- bus_addr, bus_wdata  out  32  bus address / write data
- bus_sel  out  4  bus byte enables
- bus_rdata  in  32  bus read data, valid with bus_ack
- bus_ack  in  1  one-cycle transfer acknowledge

## Operation
- States: IDLE, I_BUS, I_FILL, D_BUS, D_DONE.
- IDLE: samples requests. Only i_req → I_BUS. Only d_read|d_write → D_BUS. Both → grant the side not granted last (last_grant flag; reset value = instruction, so data wins first tie). On grant, latch address/wdata/sel/we and update last_grant.
- I_BUS: bus_req=1, bus_we=0, bus_sel=4'hF, bus_addr = latched i_addr with [1:0]=0. bus_ack → capture bus_rdata → I_FILL.
- I_FILL: i_fill=1, i_done=1, i_instr = captured word → IDLE.
- D_BUS: bus_req=1, bus_we=latched d_write, bus_sel=latched d_sel, bus_addr/bus_wdata latched. bus_ack → capture bus_rdata into d_rdata (reads only; writes leave d_rdata unchanged) → D_DONE.
- D_DONE: d_done=1 → IDLE.
- d_read and d_write both high: treated as write.
- Requests changing or dropping while in *_BUS are ignored; the latched transaction completes.
- Timeout: counter clears on entry to *_BUS, increments each cycle without ack. Reaching TIMEOUT without ack: bus_req drops, captured data = 32'h0, err=1 in the following I_FILL/D_DONE cycle. bus_ack and timeout in the same cycle: ack wins, no err.
- A zero fetched word is still strobed on i_fill. The cache does not store a zero word, so the core consumes i_instr on i_done.
- bus_ack outside *_BUS is ignored.

## Timing
- Reset (nrst low, asynchronous): state IDLE, all outputs 0, i_instr/d_rdata 0, counter 0, last_grant = instruction. Reset mid-transaction aborts it immediately with no done pulse.
- All outputs derive from registered state/latches. No combinational path from request inputs to bus outputs.
- Request sampled at edge k. bus_req high from cycle k+1. Ack in cycle m → done/fill pulse in cycle m+1 → IDLE in cycle m+2. Zero-wait-state bus: request to done is 2 cycles, 3 cycles request to next sample.
- A request still asserted in the first IDLE cycle after done is a new request. The requester drops the request on observing done. The i_req source drops automatically because the cache hit registers at the I_FILL edge.

## Structure
- Package t03_mem_pkg: state enum (arb_state_t: IDLE, I_BUS, I_FILL, D_BUS, D_DONE), grant enum (GRANT_I, GRANT_D), default TIMEOUT constant.
- One sub-module: t03_bus_timeout (clear, enable, CNT_W counter, expired flag), instantiated once.

## Test plan
- Fetch miss, i_addr=32'h0000_0046, ack after 2 wait cycles with rdata=32'h0051_0113 → bus_addr=32'h0000_0044, bus_sel=4'hF, one-cycle i_fill/i_done with i_instr=32'h0051_0113, err=0.
- Store, d_addr=32'h100, d_wdata=32'hDEAD_BEEF, d_sel=4'b0011, zero-wait ack → bus_we=1 with those values, d_done in cycle 2, d_rdata unchanged.
- i_req and d_read asserted together after reset → data granted first, then instruction. Repeated ties alternate grants.
- No ack for TIMEOUT=4 → bus_req low after 4 cycles, d_done+err pulse, d_rdata=0, then IDLE.
- d_read dropped mid-D_BUS, ack arrives → transaction still completes with d_done. nrst pulsed low during I_BUS → bus_req, i_fill, i_done low at once, state IDLE.
- bus_ack on the same cycle the timeout expires → normal completion, err=0.
